zigzag_rle: RTL

//  JPEG entropy front end for one 8x8 block. Consumes 64 quantized coefficients in zigzag order
//  (0=DC, 1..63=AC), as read from the coefficient RAM at the addresses produced by the zigzag read

---
 rtl/zigzag_rle.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/zigzag_rle.sv
// Zigzag-ordered 8x8 coefficient block -> JPEG DC-diff / AC (run,size,amp) / ZRL / EOB symbols.
// One-cycle latency through a single output register; input stalls while ZRLs are flushed.
module zigzag_rle #(
   parameter int COEF_W = 11,
   parameter int AMP_W  = 12
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     dc_clear,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic signed [COEF_W-1:0] in_data,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic                     out_is_dc,
   output logic [3:0]               out_run,
   output logic [3:0]               out_size,
   output logic [AMP_W-1:0]         out_amp,
   output logic                     out_last
);

   typedef enum logic [1:0] {ST_DC, ST_AC, ST_FLUSH} state_e;

   function automatic logic [3:0] mag_size(input logic signed [AMP_W-1:0] v);
      logic [AMP_W-1:0] mag;
      mag_size = '0;
      mag = v[AMP_W-1] ? -v : v;
      for (int i = 0; i < AMP_W; i++)
         if (mag[i]) mag_size = 4'(i + 1);
   endfunction

   // Negative values are sent as (v-1) truncated to size bits.
   function automatic logic [AMP_W-1:0] amp_bits(input logic signed [AMP_W-1:0] v,
                                                 input logic [3:0] s);
      logic [AMP_W-1:0] raw;
      raw = v[AMP_W-1] ? (v - AMP_W'(1)) : v;
      amp_bits = raw & ~({AMP_W{1'b1}} << s);
   endfunction

   state_e                   state_q, state_d;
   logic [5:0]               idx_q, idx_d;
   logic [3:0]               zero_run_q, zero_run_d;
   logic [1:0]               zrl_cnt_q, zrl_cnt_d;
   logic signed [COEF_W-1:0] dc_pred_q, dc_pred_d;
   logic [3:0]               lat_run_q, lat_run_d, lat_size_q, lat_size_d;
   logic [AMP_W-1:0]         lat_amp_q, lat_amp_d;
   logic                     lat_last_q, lat_last_d;
   logic                     out_valid_q, out_is_dc_q, out_last_q;
   logic [3:0]               out_run_q, out_size_q;
   logic [AMP_W-1:0]         out_amp_q;

   logic                     adv, accept, emit, e_is_dc, e_last;
   logic [3:0]               e_run, e_size, coef_size, diff_size;
   logic [AMP_W-1:0]         e_amp;
   logic signed [AMP_W-1:0]  coef_ext, pred_ext, dc_diff;

   assign adv      = !out_valid_q || out_ready;
   assign in_ready = rst_n && (state_q != ST_FLUSH) && adv;
   assign accept   = in_valid && in_ready;

   assign coef_ext  = {{(AMP_W-COEF_W){in_data[COEF_W-1]}}, in_data};
   assign pred_ext  = dc_clear ? '0 : {{(AMP_W-COEF_W){dc_pred_q[COEF_W-1]}}, dc_pred_q};
   assign dc_diff   = coef_ext - pred_ext;
   assign coef_size = mag_size(coef_ext);
   assign diff_size = mag_size(dc_diff);

   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      zero_run_d = zero_run_q;
      zrl_cnt_d  = zrl_cnt_q;
      dc_pred_d  = dc_clear ? '0 : dc_pred_q;
      lat_run_d  = lat_run_q;
      lat_size_d = lat_size_q;
      lat_amp_d  = lat_amp_q;
      lat_last_d = lat_last_q;
      emit       = 1'b0;
      e_is_dc    = 1'b0;
      e_run      = '0;
      e_size     = '0;
      e_amp      = '0;
      e_last     = 1'b0;
      case (state_q)
         ST_DC: if (accept) begin
            idx_d      = idx_q + 6'd1;
            dc_pred_d  = in_data;
            zero_run_d = '0;
            zrl_cnt_d  = '0;
            emit       = 1'b1;
            e_is_dc    = 1'b1;
            e_size     = diff_size;
            e_amp      = amp_bits(dc_diff, diff_size);
            state_d    = ST_AC;
         end
         ST_AC: if (accept) begin
            idx_d = idx_q + 6'd1;
            if (in_data == '0) begin
               if (idx_q == 6'd63) begin
                  emit       = 1'b1;
                  e_last     = 1'b1;
                  zero_run_d = '0;
                  zrl_cnt_d  = '0;
                  state_d    = ST_DC;
               end else if (zero_run_q == 4'd15) begin
                  zero_run_d = '0;
                  if (zrl_cnt_q != 2'd3) zrl_cnt_d = zrl_cnt_q + 2'd1;
               end else begin
                  zero_run_d = zero_run_q + 4'd1;
               end
            end else if (zrl_cnt_q == '0) begin
               emit       = 1'b1;
               e_run      = zero_run_q;
               e_size     = coef_size;
               e_amp      = amp_bits(coef_ext, coef_size);
               e_last     = (idx_q == 6'd63);
               zero_run_d = '0;
               if (idx_q == 6'd63) state_d = ST_DC;
            end else begin
               // First ZRL goes out in the accept slot; the rest plus the symbol drain in FLUSH.
               emit       = 1'b1;
               e_run      = 4'd15;
               zrl_cnt_d  = zrl_cnt_q - 2'd1;
               lat_run_d  = zero_run_q;
               lat_size_d = coef_size;
               lat_amp_d  = amp_bits(coef_ext, coef_size);
               lat_last_d = (idx_q == 6'd63);
               zero_run_d = '0;
               state_d    = ST_FLUSH;
            end
         end
         ST_FLUSH: if (adv) begin
            emit = 1'b1;
            if (zrl_cnt_q != '0) begin
               e_run     = 4'd15;
               zrl_cnt_d = zrl_cnt_q - 2'd1;
            end else begin
               e_run   = lat_run_q;
               e_size  = lat_size_q;
               e_amp   = lat_amp_q;
               e_last  = lat_last_q;
               state_d = lat_last_q ? ST_DC : ST_AC;
            end
         end
         default: state_d = ST_DC;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_DC;
         idx_q       <= '0;
         zero_run_q  <= '0;
         zrl_cnt_q   <= '0;
         dc_pred_q   <= '0;
         lat_run_q   <= '0;
         lat_size_q  <= '0;
         lat_amp_q   <= '0;
         lat_last_q  <= 1'b0;
         out_valid_q <= 1'b0;
         out_is_dc_q <= 1'b0;
         out_run_q   <= '0;
         out_size_q  <= '0;
         out_amp_q   <= '0;
         out_last_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         idx_q      <= idx_d;
         zero_run_q <= zero_run_d;
         zrl_cnt_q  <= zrl_cnt_d;
         dc_pred_q  <= dc_pred_d;
         lat_run_q  <= lat_run_d;
         lat_size_q <= lat_size_d;
         lat_amp_q  <= lat_amp_d;
         lat_last_q <= lat_last_d;
         if (emit) begin
            out_valid_q <= 1'b1;
            out_is_dc_q <= e_is_dc;
            out_run_q   <= e_run;
            out_size_q  <= e_size;
            out_amp_q   <= e_amp;
            out_last_q  <= e_last;
         end else if (out_ready) begin
            out_valid_q <= 1'b0;
         end
      end
   end

   assign out_valid = out_valid_q;
   assign out_is_dc = out_is_dc_q;
   assign out_run   = out_run_q;
   assign out_size  = out_size_q;
   assign out_amp   = out_amp_q;
   assign out_last  = out_last_q;

endmodule
